// File: rtl/systolic_matmul_engine_pkg.sv
// Shared types and width helpers for the systolic matrix-multiply engine.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Result width: full signed product plus headroom for k accumulations and one
  // extra bit so an accumulate-mode rerun of the same operands still fits.
  function automatic int acc_width(input int data_w, input int k);
    return 2 * data_w + $clog2(k) + 1;
  endfunction

  // Width of a counter that must reach the value last.
  function automatic int skew_w(input int last);
    return (last < 1) ? 1 : $clog2(last + 1);
  endfunction

endpackage

// File: rtl/systolic_matmul_engine_if.sv
// Operand/result bus with start/busy/done handshake for the matmul engine.
interface systolic_matmul_engine_if
  import systolic_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int K_DEPTH = 4,
  parameter int ACC_W   = acc_width(DATA_W, K_DEPTH)
);
  logic                     start;
  logic                     acc_mode;
  logic signed [DATA_W-1:0] a_matrix [ROWS][K_DEPTH];
  logic signed [DATA_W-1:0] b_matrix [K_DEPTH][COLS];
  logic                     busy;
  logic                     done;
  logic signed [ACC_W-1:0]  result_matrix [ROWS][COLS];

  modport master (
    output start, acc_mode, a_matrix, b_matrix,
    input  busy, done, result_matrix
  );

  modport slave (
    input  start, acc_mode, a_matrix, b_matrix,
    output busy, done, result_matrix
  );
endinterface

// File: rtl/systolic_matmul_engine_pe.sv
// Output-stationary processing element: forwards operands right/down and
// accumulates their signed product.
module systolic_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  acc
);
  logic [2*DATA_W-1:0]     prod;
  logic signed [ACC_W-1:0] acc_q;

  // acc presents the value the accumulator takes on the coming edge, so the
  // final product of a pass is visible on the same edge the result is copied.
  always_comb begin
    prod = {{DATA_W{a_in[DATA_W-1]}}, a_in} * {{DATA_W{b_in[DATA_W-1]}}, b_in};
    acc  = acc_q;
    if (en) acc = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  end

  // Operand pipeline flushes to zero whenever the array is not computing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_out <= '0;
      b_out <= '0;
      acc_q <= '0;
    end else begin
      a_out <= en ? a_in : '0;
      b_out <= en ? b_in : '0;
      acc_q <= clear ? '0 : acc;
    end
  end
endmodule

// File: rtl/systolic_matmul_engine.sv
// Output-stationary systolic C = A x B engine with internal operand skewing,
// start/busy/done handshake and optional accumulation onto prior results.
module systolic_matmul_engine
  import systolic_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int K_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  systolic_matmul_engine_if.slave bus
);
  localparam int ACC_W  = acc_width(DATA_W, K_DEPTH);
  localparam int T_LAST = K_DEPTH + ROWS + COLS - 3;
  localparam int TW     = skew_w(T_LAST);

  state_t                   state, state_n;
  logic [TW-1:0]            t;
  logic                     load, clear, en, last;
  logic signed [DATA_W-1:0] a_q [ROWS][K_DEPTH];
  logic signed [DATA_W-1:0] b_q [K_DEPTH][COLS];
  logic signed [DATA_W-1:0] a_edge [ROWS];
  logic signed [DATA_W-1:0] b_edge [COLS];
  logic signed [DATA_W-1:0] a_pipe [ROWS][COLS];
  logic signed [DATA_W-1:0] b_pipe [ROWS][COLS];
  logic signed [ACC_W-1:0]  pe_acc [ROWS][COLS];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and control decode.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    clear   = 1'b0;
    en      = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          clear   = !bus.acc_mode;
          state_n = COMPUTE;
        end
      end
      COMPUTE: begin
        en   = 1'b1;
        last = (t == TW'(T_LAST));
        if (last) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);

  // Skew counter and operand capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t   <= '0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
    end else if (load) begin
      t   <= '0;
      a_q <= bus.a_matrix;
      b_q <= bus.b_matrix;
    end else if (en && !last) begin
      t <= t + 1'b1;
    end
  end

  // Edge skew: row i sees A[i][t-i], column j sees B[t-j][j], zero outside range.
  always_comb begin
    for (int unsigned i = 0; i < ROWS; i++) begin
      a_edge[i] = '0;
      for (int unsigned k = 0; k < K_DEPTH; k++)
        if (en && int'(t) == int'(i + k)) a_edge[i] = a_q[i][k];
    end
    for (int unsigned j = 0; j < COLS; j++) begin
      b_edge[j] = '0;
      for (int unsigned k = 0; k < K_DEPTH; k++)
        if (en && int'(t) == int'(j + k)) b_edge[j] = b_q[k][j];
    end
  end

  // Result register, loaded with the post-final-product accumulators.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    bus.result_matrix <= '{default: '0};
    else if (last) bus.result_matrix <= pe_acc;
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic signed [DATA_W-1:0] a_in, b_in;
      if (j == 0) begin : g_a_edge
        assign a_in = a_edge[i];
      end else begin : g_a_pipe
        assign a_in = a_pipe[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in = b_edge[j];
      end else begin : g_b_pipe
        assign b_in = b_pipe[i-1][j];
      end
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .en    (en),
        .a_in  (a_in),
        .b_in  (b_in),
        .a_out (a_pipe[i][j]),
        .b_out (b_pipe[i][j]),
        .acc   (pe_acc[i][j])
      );
    end
  end
endmodule

// File: doc/systolic_matmul_engine.md
# systolic_matmul_engine

Parametrised output-stationary systolic matrix-multiply engine that computes C = A × B for a ROWS×K_DEPTH operand A and a K_DEPTH×COLS operand B, all signed. It supersedes the fixed square array. Additions over that array:
- internal operand skewing,
- a start/busy/done handshake,
- non-square shapes,
- an accumulate mode that adds a new product onto the previous result.

It sits between the NPU operand buffers and the result write-back path.

## Interface
- DATA_W, 8, operand width (signed two's complement)
- ROWS, 4, rows of A, C and the PE grid
- COLS, 4, columns of B, C and the PE grid
- K_DEPTH, 4, inner dimension
- ACC_W, 2*DATA_W+$clog2(K_DEPTH)+1, result width (derived; not overridden)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- start  in  1  request; sampled only in IDLE
- acc_mode  in  1  sampled with start: 1 = add onto current results, 0 = overwrite
- a_matrix  in  [DATA_W-1:0] [ROWS][K_DEPTH]  operand A, sampled on the start edge
- b_matrix  in  [DATA_W-1:0] [K_DEPTH][COLS]  operand B, sampled on the start edge
- busy  out  1  high from the start edge until the edge that leaves DONE
- done  out  1  one-cycle pulse, result_matrix valid
- result_matrix  out  [ACC_W-1:0] [ROWS][COLS]  signed C, held between done pulses

## Operation
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - start=1 captures a_matrix, b_matrix and acc_mode into internal registers.
  - If acc_mode=0, all PE accumulators clear to 0; if acc_mode=1, they keep their values.
  - Skew counter t is set to 0 and the FSM moves to COMPUTE.
- COMPUTE, each cycle:
  - Left edge of row i is driven with A[i][t-i] when 0 ≤ t-i < K_DEPTH, else 0.
  - Top edge of column j is driven with B[t-j][j] when 0 ≤ t-j < K_DEPTH, else 0.
  - Each PE registers a_out ← a_in and b_out ← b_in, and does acc ← acc + sext(a_in)·sext(b_in).
  - PE(i,j) therefore consumes k = t-i-j.
  - t runs 0 … K_DEPTH+ROWS+COLS-3. On the last value the FSM goes to DONE and copies the accumulators to result_matrix.
- DONE: done=1 for one cycle, then IDLE. busy is 0 in IDLE only.
- Arithmetic: full signed product 2·DATA_W bits, sign-extended to ACC_W. Accumulation wraps modulo 2^ACC_W and does not saturate. ACC_W cannot overflow in a single pass.
- Operand inputs change freely after the start edge without affecting the run.
- start while busy is ignored; it is not queued.
- start and reset release in the same cycle: reset wins, so start is ignored until reset is deasserted at an edge.

## Timing
- Reset values (async, immediate):
  - FSM = IDLE, busy=0, done=0
  - result_matrix and all accumulators = 0
  - all PE pipeline registers = 0
  - t = 0
- Reset asserted mid-COMPUTE aborts the run. No done is issued and the next acc_mode=1 run accumulates from 0.
- Latency: done rises on the edge K_DEPTH+ROWS+COLS-2 edges after the start-sampling edge. With default parameters this is 10.
- result_matrix updates on the same edge done rises.
- busy rises on the start edge and falls on the edge after done.
- Minimum start-to-start spacing is K_DEPTH+ROWS+COLS cycles. A start held high in IDLE on the cycle after DONE begins a new run.

## Structure
- Package systolic_pkg holds:
  - state enum state_t {IDLE, COMPUTE, DONE}
  - function acc_width(data_w, k) returning 2*data_w+$clog2(k)+1
  - skew-counter width localparam helper
- Sub-module systolic_pe:
  - parameters DATA_W and ACC_W
  - ports clk, reset, clear, en, a_in, b_in, a_out, b_out, acc
  - instantiated ROWS×COLS times in a generate grid
- Edge skew muxes and the FSM live in the top module.

## Test plan
- Defaults, A all 1, B all -1, acc_mode=0 → every result = -4; done exactly 10 cycles after the start edge; busy high for 11 cycles.
- A = identity (4×4), B[k][j] = 10k+j → result equals B exactly. Then apply a second start with A all 0 and acc_mode=0 → all results 0.
- A all -128, B all -128 → every result = 65536; no wrap at ACC_W=19. Issue a second identical start with acc_mode=1 → 131072.
- Pulse start again at cycle 3 of COMPUTE with different operands → ignored: result matches the first operands, a single done pulse is seen, and no extra run follows.
- Assert reset at cycle 5 of COMPUTE → busy, done and result_matrix are 0 immediately, no done follows, and the FSM is in IDLE.
- ROWS=2, COLS=3, K_DEPTH=5, random signed operands → result matches a golden model, done arrives 8 cycles after the start edge, and ACC_W=20.
